// File: rtl/urna_pkg.sv
`default_nettype none
// ============================================================================
// Module   : urna_pkg
// Brief    : Shared types and constants for the voting-booth arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package urna_pkg;

    localparam int C_N_BOOTH_DEF = 4;
    localparam int C_CODE_W_DEF  = 4;
    localparam int C_VOTES_W     = 16;

    typedef enum logic [1:0] {
        PH_CLOSED   = 2'b00,
        PH_OPEN     = 2'b01,
        PH_DRAIN    = 2'b10,
        PH_FINISHED = 2'b11
    } phase_t;

    // Counter holds at all-ones rather than wrapping back to zero.
    function automatic logic [C_VOTES_W-1:0] sat_inc(input logic [C_VOTES_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/urna_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : urna_rr_arbiter
// Brief    : Round-robin selector; search begins one past the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module urna_rr_arbiter
    import urna_pkg::*;
#(
    parameter  int N_BOOTH = C_N_BOOTH_DEF,
    localparam int IDX_W   = $clog2(N_BOOTH)
) (
    input  logic [N_BOOTH-1:0] req_mask,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [N_BOOTH-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        int         w_pos;
        logic [IDX_W-1:0] w_pos_idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = 1; k <= N_BOOTH; k++) begin
            w_pos = int'(last_grant) + k;
            if (w_pos >= N_BOOTH) begin
                w_pos = w_pos - N_BOOTH;
            end
            w_pos_idx = w_pos[IDX_W-1:0];
            if (!grant_any && req_mask[w_pos_idx]) begin
                grant[w_pos_idx] = 1'b1;
                grant_idx        = w_pos_idx;
                grant_any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/urna_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : urna_booth_arbiter
// Brief    : Election phase FSM, single-entry output slot and vote counter
//            sharing one tally datapath among N_BOOTH booths.
// Revision : 1.0 - initial release
// ============================================================================
module urna_booth_arbiter
    import urna_pkg::*;
#(
    parameter  int N_BOOTH = C_N_BOOTH_DEF,
    parameter  int CODE_W  = C_CODE_W_DEF,
    localparam int IDX_W   = $clog2(N_BOOTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      open_cmd,
    input  logic                      close_cmd,
    input  logic [N_BOOTH-1:0]        booth_req,
    input  logic [N_BOOTH*CODE_W-1:0] booth_code,
    output logic [N_BOOTH-1:0]        booth_ack,
    output logic                      tally_valid,
    output logic [CODE_W-1:0]         tally_code,
    output logic [IDX_W-1:0]          tally_booth,
    input  logic                      tally_ready,
    output logic [1:0]                phase,
    output logic [C_VOTES_W-1:0]      votes_total
);

    phase_t              r_phase;
    logic [IDX_W-1:0]    r_last_grant;

    logic [N_BOOTH-1:0]  w_eligible;
    logic [N_BOOTH-1:0]  w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_grant_any;
    logic                w_xfer;
    logic                w_slot_free;
    logic                w_grant_en;
    logic [CODE_W-1:0]   w_grant_code;

    // A request still high during its own ack cycle must not win again.
    assign w_eligible  = booth_req & ~booth_ack;
    assign w_xfer      = tally_valid & tally_ready;
    assign w_slot_free = ~tally_valid | tally_ready;
    assign w_grant_en  = (r_phase == PH_OPEN) & ~close_cmd & w_slot_free & w_grant_any;
    assign phase       = r_phase;

    urna_rr_arbiter #(
        .N_BOOTH   (N_BOOTH)
    ) u_rr (
        .req_mask  (w_eligible),
        .last_grant(r_last_grant),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    always_comb begin
        w_grant_code = '0;
        for (int i = 0; i < N_BOOTH; i++) begin
            if (w_grant[i]) begin
                w_grant_code = booth_code[i*CODE_W +: CODE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= PH_CLOSED;
            r_last_grant <= IDX_W'(N_BOOTH - 1);
            booth_ack    <= '0;
            tally_valid  <= 1'b0;
            tally_code   <= '0;
            tally_booth  <= '0;
            votes_total  <= '0;
        end else begin
            booth_ack <= w_grant_en ? w_grant : '0;

            // Slot refills in the same cycle it drains, sustaining one vote per cycle.
            if (w_grant_en) begin
                tally_valid  <= 1'b1;
                tally_code   <= w_grant_code;
                tally_booth  <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end else if (w_xfer) begin
                tally_valid  <= 1'b0;
            end

            if (w_xfer) begin
                votes_total <= sat_inc(votes_total);
            end

            case (r_phase)
                PH_CLOSED: begin
                    if (open_cmd) begin
                        r_phase <= PH_OPEN;
                    end
                end
                PH_OPEN: begin
                    if (close_cmd) begin
                        r_phase <= PH_DRAIN;
                    end
                end
                PH_DRAIN: begin
                    if (w_slot_free) begin
                        r_phase <= PH_FINISHED;
                    end
                end
                PH_FINISHED: begin
                    r_phase <= PH_FINISHED;
                end
                default: begin
                    r_phase <= PH_CLOSED;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_urna_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_urna_booth_arbiter
// Brief    : Directed self-checking bench for urna_booth_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_urna_booth_arbiter;

    logic        clk;
    logic        rst_n;
    logic        open_cmd;
    logic        close_cmd;
    logic [3:0]  booth_req;
    logic [15:0] booth_code;
    logic [3:0]  booth_ack;
    logic        tally_valid;
    logic [3:0]  tally_code;
    logic [1:0]  tally_booth;
    logic        tally_ready;
    logic [1:0]  phase;
    logic [15:0] votes_total;

    int n_cmp = 0;
    int n_err = 0;

    urna_booth_arbiter #(
        .N_BOOTH    (4),
        .CODE_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .open_cmd   (open_cmd),
        .close_cmd  (close_cmd),
        .booth_req  (booth_req),
        .booth_code (booth_code),
        .booth_ack  (booth_ack),
        .tally_valid(tally_valid),
        .tally_code (tally_code),
        .tally_booth(tally_booth),
        .tally_ready(tally_ready),
        .phase      (phase),
        .votes_total(votes_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; open_cmd = 1'b0; close_cmd = 1'b0;
        booth_req = '0; booth_code = '0; tally_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_open();
        open_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; open_cmd = 1'b0; close_cmd = 1'b0;
        booth_req = '0; booth_code = '0; tally_ready = 1'b0;
        #2;
        n_cmp++; if (phase !== 2'b00) begin n_err++; $display("FAIL reset_phase: got %b want 00", phase); end
        n_cmp++; if (booth_ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", booth_ack); end
        n_cmp++; if (tally_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tally_valid); end
        n_cmp++; if (tally_code !== 4'h0 || tally_booth !== 2'd0) begin n_err++; $display("FAIL reset_tally: got code %h booth %0d want 0/0", tally_code, tally_booth); end
        n_cmp++; if (votes_total !== 16'd0) begin n_err++; $display("FAIL reset_total: got %0d want 0", votes_total); end
    endtask

    task automatic test_single();
        do_reset();
        do_open();
        n_cmp++; if (phase !== 2'b01) begin n_err++; $display("FAIL single_open: got %b want 01", phase); end
        booth_code = 16'h0001; booth_req = 4'b0001; tally_ready = 1'b1;
        tick();
        n_cmp++; if (booth_ack !== 4'b0001) begin n_err++; $display("FAIL single_ack: got %b want 0001", booth_ack); end
        n_cmp++; if (tally_valid !== 1'b1 || tally_code !== 4'h1 || tally_booth !== 2'd0) begin n_err++; $display("FAIL single_tally: got v%b c%h b%0d want v1 c1 b0", tally_valid, tally_code, tally_booth); end
        // request deliberately left high through the ack cycle
        tick();
        n_cmp++; if (booth_ack !== 4'b0000 || tally_valid !== 1'b0) begin n_err++; $display("FAIL single_mask: got ack %b v%b want 0000 v0", booth_ack, tally_valid); end
        n_cmp++; if (votes_total !== 16'd1) begin n_err++; $display("FAIL single_total: got %0d want 1", votes_total); end
        booth_req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        logic [3:0] exp_code;
        do_reset();
        do_open();
        booth_code = 16'hDCBA; booth_req = 4'b1111; tally_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_ack  = 4'b0001 << k;
            exp_code = 4'hA + 4'(k);
            n_cmp++; if (booth_ack !== exp_ack || tally_booth !== 2'(k) || tally_code !== exp_code) begin n_err++; $display("FAIL rr_step%0d: got ack %b b%0d c%h want ack %b b%0d c%h", k, booth_ack, tally_booth, tally_code, exp_ack, k, exp_code); end
            booth_req[k] = 1'b0;
        end
        tick();
        n_cmp++; if (tally_valid !== 1'b0 || votes_total !== 16'd4) begin n_err++; $display("FAIL rr_total: got v%b total %0d want v0 total 4", tally_valid, votes_total); end
    endtask

    task automatic test_backpressure();
        do_reset();
        do_open();
        booth_code = 16'h0765; booth_req = 4'b0001; tally_ready = 1'b0;
        tick();
        n_cmp++; if (booth_ack !== 4'b0001 || tally_code !== 4'h5) begin n_err++; $display("FAIL bp_first: got ack %b c%h want 0001 c5", booth_ack, tally_code); end
        booth_req = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (booth_ack !== 4'b0000 || tally_valid !== 1'b1 || tally_code !== 4'h5 || tally_booth !== 2'd0) begin n_err++; $display("FAIL bp_hold%0d: got ack %b v%b c%h b%0d want 0000 v1 c5 b0", k, booth_ack, tally_valid, tally_code, tally_booth); end
        end
        tally_ready = 1'b1;
        tick();
        n_cmp++; if (booth_ack !== 4'b0010 || tally_code !== 4'h6 || tally_booth !== 2'd1 || votes_total !== 16'd1) begin n_err++; $display("FAIL bp_resume1: got ack %b c%h b%0d t%0d want 0010 c6 b1 t1", booth_ack, tally_code, tally_booth, votes_total); end
        booth_req[1] = 1'b0;
        tick();
        n_cmp++; if (booth_ack !== 4'b0100 || tally_code !== 4'h7 || tally_booth !== 2'd2 || votes_total !== 16'd2) begin n_err++; $display("FAIL bp_resume2: got ack %b c%h b%0d t%0d want 0100 c7 b2 t2", booth_ack, tally_code, tally_booth, votes_total); end
        booth_req[2] = 1'b0;
        tick();
        n_cmp++; if (tally_valid !== 1'b0 || votes_total !== 16'd3) begin n_err++; $display("FAIL bp_end: got v%b t%0d want v0 t3", tally_valid, votes_total); end
    endtask

    task automatic test_drain();
        do_reset();
        do_open();
        booth_code = 16'h0039; booth_req = 4'b0001; tally_ready = 1'b0;
        tick();
        booth_req = 4'b0010; close_cmd = 1'b1;
        tick();
        close_cmd = 1'b0;
        n_cmp++; if (phase !== 2'b10 || booth_ack !== 4'b0000 || tally_valid !== 1'b1 || tally_code !== 4'h9) begin n_err++; $display("FAIL drain_enter: got ph%b ack %b v%b c%h want 10 0000 v1 c9", phase, booth_ack, tally_valid, tally_code); end
        tick();
        n_cmp++; if (phase !== 2'b10 || booth_ack !== 4'b0000) begin n_err++; $display("FAIL drain_hold: got ph%b ack %b want 10 0000", phase, booth_ack); end
        tally_ready = 1'b1;
        tick();
        n_cmp++; if (phase !== 2'b11 || votes_total !== 16'd1 || tally_valid !== 1'b0) begin n_err++; $display("FAIL drain_done: got ph%b t%0d v%b want 11 t1 v0", phase, votes_total, tally_valid); end
        open_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
        tick();
        n_cmp++; if (phase !== 2'b11 || booth_ack !== 4'b0000 || votes_total !== 16'd1) begin n_err++; $display("FAIL finished_stay: got ph%b ack %b t%0d want 11 0000 t1", phase, booth_ack, votes_total); end
        booth_req = 4'b0000;
    endtask

    task automatic test_closed_ignore();
        do_reset();
        booth_code = 16'h4321; booth_req = 4'b1111; tally_ready = 1'b1; close_cmd = 1'b1;
        tick();
        close_cmd = 1'b0;
        tick();
        n_cmp++; if (phase !== 2'b00 || booth_ack !== 4'b0000 || tally_valid !== 1'b0) begin n_err++; $display("FAIL closed_ignore: got ph%b ack %b v%b want 00 0000 v0", phase, booth_ack, tally_valid); end
        open_cmd = 1'b1; close_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
        n_cmp++; if (phase !== 2'b01 || booth_ack !== 4'b0000) begin n_err++; $display("FAIL both_cmds: got ph%b ack %b want 01 0000", phase, booth_ack); end
        tick();
        close_cmd = 1'b0;
        n_cmp++; if (phase !== 2'b10 || booth_ack !== 4'b0000 || tally_valid !== 1'b0) begin n_err++; $display("FAIL close_blocks: got ph%b ack %b v%b want 10 0000 v0", phase, booth_ack, tally_valid); end
        tick();
        n_cmp++; if (phase !== 2'b11 || booth_ack !== 4'b0000 || votes_total !== 16'd0) begin n_err++; $display("FAIL empty_drain: got ph%b ack %b t%0d want 11 0000 t0", phase, booth_ack, votes_total); end
        booth_req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_open();
        booth_code = 16'h0003; booth_req = 4'b0001; tally_ready = 1'b0;
        tick();
        n_cmp++; if (tally_valid !== 1'b1 || tally_code !== 4'h3) begin n_err++; $display("FAIL mid_held: got v%b c%h want v1 c3", tally_valid, tally_code); end
        booth_req = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (phase !== 2'b00 || booth_ack !== 4'b0000 || tally_valid !== 1'b0 || tally_code !== 4'h0 || tally_booth !== 2'd0 || votes_total !== 16'd0) begin n_err++; $display("FAIL mid_async: got ph%b ack %b v%b c%h b%0d t%0d want all zero", phase, booth_ack, tally_valid, tally_code, tally_booth, votes_total); end
        tally_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (votes_total !== 16'd0 || tally_valid !== 1'b0 || phase !== 2'b00) begin n_err++; $display("FAIL mid_discard: got t%0d v%b ph%b want t0 v0 ph00", votes_total, tally_valid, phase); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_closed_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
